// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 (double dabble) binary to packed BCD.
// Ports: clk, rst (sync, active-high), start, bin_in -> busy, done, bcd_out, ovf (BIN2BCD_OVF_EN).
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] bin_d;
  logic [BCD_W-1:0] acc_q;
  logic [BCD_W-1:0] acc_d;
  logic [BCD_W-1:0] acc_fix;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       dig;

`ifdef BIN2BCD_OVF_EN
  logic flag_q;
  logic flag_d;
  logic ovf_q;
  logic ovf_d;
`endif

  // Per-digit +3 correction; digits stay <= 9 so the 4-bit add never wraps.
  always_comb begin
    acc_fix = acc_q;
    dig     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = acc_q[4*i +: 4];
      if (dig >= 4'd5) begin
        acc_fix[4*i +: 4] = dig + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
`ifdef BIN2BCD_OVF_EN
    flag_d  = flag_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          bin_d   = bin_in;
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
`ifdef BIN2BCD_OVF_EN
          flag_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // Top bit of the corrected accumulator falls off the end.
        acc_d = BCD_W'({acc_fix, bin_q[BIN_W-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q - 1'b1;
`ifdef BIN2BCD_OVF_EN
        flag_d = flag_q | acc_fix[BCD_W-1];
`endif
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          bcd_d   = acc_d;
`ifdef BIN2BCD_OVF_EN
          ovf_d   = flag_d;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
`ifdef BIN2BCD_OVF_EN
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
`ifdef BIN2BCD_OVF_EN
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;
`ifdef BIN2BCD_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule
